// File: rtl/alu_seq.sv
// alu_seq: 8-bit sequential ALU sitting behind the register block.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/SHR) write result and flags at the
// start edge. The multi-cycle shift-add MUL is built only when the
// ALU_SEQ_MUL_EN macro is defined; without it, op 111 is a NOP that still
// pulses done. The result is returned to the shared bus through a tristate
// driver gated by oe.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             oe,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [WIDTH-1:0] result;
  logic [9:0]       calc;   // {v, c, result}

  // Single-cycle datapath; overflow comes from sign-extended 9-bit arithmetic
  function automatic logic [9:0] alu_calc(input logic [2:0] f_op,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
    logic        [8:0] wide;
    logic signed [8:0] sx;
    logic signed [8:0] sy;
    logic signed [8:0] ssum;
    logic        [7:0] r;
    logic              c;
    logic              v;
    wide = 9'd0;
    ssum = 9'sd0;
    sx   = $signed({x[7], x});
    sy   = $signed({y[7], y});
    r    = 8'd0;
    c    = 1'b0;
    v    = 1'b0;
    case (f_op)
      OP_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        ssum = sx + sy;
        r    = wide[7:0];
        c    = wide[8];
        v    = ssum[8] ^ ssum[7];
      end
      OP_SUB: begin
        wide = {1'b0, x} - {1'b0, y};
        ssum = sx - sy;
        r    = wide[7:0];
        c    = wide[8];
        v    = ssum[8] ^ ssum[7];
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHL: begin
        r = {x[6:0], 1'b0};
        c = x[7];
      end
      OP_SHR: begin
        r = {1'b0, x[7:1]};
        c = x[0];
      end
      default: r = 8'd0;
    endcase
    return {v, c, r};
  endfunction

  assign calc = alu_calc(op, a, b);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] acc;
  logic [15:0] acc_nxt;
  logic [15:0] a_sh;
  logic [7:0]  b_sh;
  logic [2:0]  cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and one shift-add step of the multiplier
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc + (b_sh[0] ? a_sh : 16'd0);
    case (state)
      IDLE: if (start && op == OP_MUL) state_nxt = MUL;
      MUL:  if (cnt == 3'd7)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == MUL);
`else
  assign busy = 1'b0;
`endif

  // Result/flag registers, done pulse and multiplier iteration state
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc    <= 16'd0;
      a_sh   <= 16'd0;
      b_sh   <= 8'd0;
      cnt    <= 3'd0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      if (state == MUL) begin
        acc  <= acc_nxt;
        a_sh <= {a_sh[14:0], 1'b0};
        b_sh <= {1'b0, b_sh[7:1]};
        cnt  <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          result <= acc_nxt[7:0];
          flag_z <= (acc_nxt[7:0] == 8'd0);
          flag_c <= |acc_nxt[15:8];
          flag_n <= acc_nxt[7];
          flag_v <= 1'b0;
          done   <= 1'b1;
        end
      end else if (start && op == OP_MUL) begin
        a_sh <= {8'd0, a};
        b_sh <= b;
        acc  <= 16'd0;
        cnt  <= 3'd0;
      end else
`endif
      if (start) begin
        // op 111 only reaches here as a NOP: flags and result hold
        if (op != OP_MUL) begin
          result <= calc[7:0];
          flag_z <= (calc[7:0] == 8'd0);
          flag_c <= calc[8];
          flag_n <= calc[7];
          flag_v <= calc[9];
        end
        done <= 1'b1;
      end
    end
  end

  assign out = oe ? result : {WIDTH{1'bz}};

endmodule
